mp_result_wr: RTL
=================

// Module: mp_result_wr
// PURPOSE
//  Bus-master write-back engine for the multiplier project: the outbound counterpart of operand capture.
//  - Operand capture reads op/Ra/Rb over the bus; this block writes the 64-bit product and a status word back.
//  - Sits between the multiplier core (result, done strobe) and the shared bus arbiter.
//  - Raises m_interrupt once both words are committed.
// PARAMETERS
//  ADDR_W       8       bus address width
//  RESULT_ADDR  8'h02   address receiving the 64-bit product
//  STATUS_ADDR  8'h03   address receiving the status word
// PORTS
//  clk          in   1   single clock, all state updates on rising edge
//  reset        in   1   synchronous, active-high; clears every register
//  start        in   1   1-cycle strobe from core: result and op are valid this cycle
//  result       in   64  product from core
//  op           in   16  opcode of the finished operation
//  m_grant      in   1   arbiter grant; a beat commits on a cycle with m_req & m_grant
//  m_req        out  1   bus request
//  m_wr         out  1   write enable (1 whenever m_req=1)
//  m_addr       out  ADDR_W  write address
//  m_dout       out  64  write data
//  busy         out  1   state != IDLE
//  done         out  1   1-cycle pulse after status beat commits
//  m_interrupt  out  1   same cycle as done
//  wr_count     out  16  completed write-backs, wraps 16'hFFFF -> 0
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0; latched result/op = 0; wr_count = 0. Reset wins over start.
//  - Outputs are Moore: decoded from the state and latched registers only. No input reaches an output combinationally.
//  - FSM states: IDLE, WR_RES, WR_STAT, DONE. Encodings are 2-bit, held in the package.
//  - IDLE: start=1 latches result/op; next state WR_RES.
//      start is honoured only in IDLE. start in any other state is ignored; there is no queue.
//  - WR_RES: m_req=1, m_wr=1, m_addr=RESULT_ADDR, m_dout=latched result.
//      m_grant=1 -> WR_STAT; otherwise hold with all bus outputs unchanged.
//  - WR_STAT: m_req=1, m_wr=1, m_addr=STATUS_ADDR, m_dout=status.
//      Status layout: [15:0]=op, [16]=1, [31:17]=0, [47:32]=wr_count+1, [63:48]=0.
//      m_grant=1 -> DONE and wr_count increments on that edge; otherwise hold.
//  - DONE: m_req=0; done=1 and m_interrupt=1 for exactly this cycle; next state IDLE.
//  - Latency: start to first possible beat is 1 cycle; with grant held high, start to done is 3 cycles.
//  - Grant dropping between beats only stalls the FSM. A beat is never re-sent once committed.
//  - Reset mid-operation: FSM returns to IDLE and m_req is 0 after that edge; wr_count is cleared.
//      A beat already committed is not undone.
//  - The latched result/op stay stable from WR_RES through DONE, even if result/op inputs change.
// STRUCTURE
//  - Package mp_pkg holds the state encodings, the RESULT_ADDR/STATUS_ADDR defaults and the status bit positions.
//      The status bit positions are shared with the firmware/testbench status decoder.
//  - No sub-module: one state register, one next-state/output always block, a latch register and the counter.
// TESTING
//  - Grant tied 1; start with result=64'h0000_0012_3456_789A, op=16'h0001.
//      -> beat 1 addr 02 data 64'h0000_0012_3456_789A; beat 2 addr 03 data 64'h0000_0001_0001_0001;
//      -> done pulse 3 cycles after start; wr_count=1.
//  - Grant low for 4 cycles in WR_RES, then low 2 cycles in WR_STAT.
//      -> m_req, m_addr and m_dout held steady while stalled; exactly 2 commits; done 9 cycles after start.
//  - start re-pulsed during WR_RES and during DONE -> ignored; only one write-back; wr_count +1 only.
//  - reset asserted while in WR_STAT with grant low -> next cycle state IDLE, m_req=0, wr_count=0, no done pulse.
//  - Preload wr_count=16'hFFFF via 65535 back-to-back ops (or force)
//      -> next status bits [47:32]=0000; wr_count wraps to 0.
//  - result input changed every cycle after start -> m_dout on the result beat equals the value sampled at start.

Source files
------------

// File: rtl/mp_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : mp_pkg
//  Purpose : Shared definitions for the multiplier result write-back engine.
//            FSM state encodings, default bus addresses and the status-word
//            bit layout. The firmware status decoder uses the same bit
//            positions, so any change here must be mirrored there.
//  Revision: 1.0 - initial release
// ============================================================================
package mp_pkg;

    // 2-bit FSM encoding for the write-back sequence
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR_RES  = 2'd1,
        ST_WR_STAT = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // Default bus addresses for the two write-back beats
    localparam logic [7:0] c_result_addr = 8'h02;
    localparam logic [7:0] c_status_addr = 8'h03;

    // Status word layout
    localparam int c_stat_op_lsb    = 0;
    localparam int c_stat_op_msb    = 15;
    localparam int c_stat_valid_bit = 16;
    localparam int c_stat_cnt_lsb   = 32;
    localparam int c_stat_cnt_msb   = 47;

    // Build the status word; every bit not named in the layout stays zero.
    function automatic logic [63:0] make_status(input logic [15:0] op_val,
                                                input logic [15:0] cnt_val);
        logic [63:0] w_s;
        w_s = '0;
        w_s[c_stat_op_msb:c_stat_op_lsb]   = op_val;
        w_s[c_stat_valid_bit]              = 1'b1;
        w_s[c_stat_cnt_msb:c_stat_cnt_lsb] = cnt_val;
        return w_s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mp_result_wr.sv
`default_nettype none
// ============================================================================
//  Module  : mp_result_wr
//  Purpose : Bus-master write-back engine. On a start strobe from the
//            multiplier core it latches the 64-bit product and opcode, writes
//            the product to RESULT_ADDR, then a status word to STATUS_ADDR,
//            and finally pulses done / m_interrupt for one cycle.
//  Ports   : clk, reset (sync, active-high)
//            start, result[63:0], op[15:0]   - core handoff
//            m_grant                         - arbiter grant
//            m_req, m_wr, m_addr, m_dout     - bus master write port
//            busy, done, m_interrupt         - status to core / CPU
//            wr_count[15:0]                  - completed write-backs (wraps)
//  Revision: 1.0 - initial release
// ============================================================================
module mp_result_wr
    import mp_pkg::*;
#(
    parameter int                ADDR_W      = 8,
    parameter logic [ADDR_W-1:0] RESULT_ADDR = ADDR_W'(c_result_addr),
    parameter logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(c_status_addr)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [63:0]       result,
    input  logic [15:0]       op,
    input  logic              m_grant,
    output logic              m_req,
    output logic              m_wr,
    output logic [ADDR_W-1:0] m_addr,
    output logic [63:0]       m_dout,
    output logic              busy,
    output logic              done,
    output logic              m_interrupt,
    output logic [15:0]       wr_count
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [63:0] r_result;
    logic [15:0] r_op;
    logic [15:0] r_wr_count;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand latch: captured only when a new write-back is accepted, so the
    // bus data stays stable even if the core changes result/op afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_result <= '0;
            r_op     <= '0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_result <= result;
            r_op     <= op;
        end
    end

    // Completed write-back counter; advances on the status-beat commit edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_count <= '0;
        end else if ((r_state == ST_WR_STAT) && m_grant) begin
            r_wr_count <= r_wr_count + 16'd1;
        end
    end

    // Next-state and Moore output decode. Outputs depend only on r_state and
    // registered data; m_grant affects only the next state.
    always_comb begin
        w_state_nxt = r_state;
        m_req       = 1'b0;
        m_wr        = 1'b0;
        m_addr      = '0;
        m_dout      = '0;
        done        = 1'b0;
        m_interrupt = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_WR_RES;
                end
            end
            ST_WR_RES: begin
                m_req  = 1'b1;
                m_wr   = 1'b1;
                m_addr = RESULT_ADDR;
                m_dout = r_result;
                if (m_grant) begin
                    w_state_nxt = ST_WR_STAT;
                end
            end
            ST_WR_STAT: begin
                m_req  = 1'b1;
                m_wr   = 1'b1;
                m_addr = STATUS_ADDR;
                // The status reports the count this write-back will produce.
                m_dout = make_status(r_op, r_wr_count + 16'd1);
                if (m_grant) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done        = 1'b1;
                m_interrupt = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign busy     = (r_state != ST_IDLE);
    assign wr_count = r_wr_count;

endmodule
`default_nettype wire
